// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and state type for the SPI write-only register file
package spi_pkg;
    localparam int FRAME_BITS = 16;
    localparam int NUM_REGS   = 5;
    localparam int ADDR_EN_OUT_7_0  = 0;
    localparam int ADDR_EN_OUT_15_8 = 1;
    localparam int ADDR_EN_PWM_7_0  = 2;
    localparam int ADDR_EN_PWM_15_8 = 3;
    localparam int ADDR_PWM_DUTY    = 4;
    typedef enum logic {IDLE, SHIFT} state_e;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing an asynchronous bit into clk
//   clk, rst_n : clock and async active-low reset (chain resets to RST_VAL)
//   d          : asynchronous input
//   q          : synchronised output
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) chain_q <= {STAGES{RST_VAL}};
        else        chain_q <= {chain_q[STAGES-2:0], d};

    assign q = chain_q[STAGES-1];
endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 write-only register file feeding the PWM block
//   clk, rst_n      : system clock, async active-low reset
//   sclk, copi, ncs : asynchronous SPI pins (16-bit frames: R/W, addr[6:0], data[7:0])
//   en_reg_*, pwm_duty_cycle : registers 0x00..0x04
//   wr_pulse        : one-cycle strobe on each committed write
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_pulse
);
    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

    logic sclk_s, copi_s, ncs_s;
    logic sclk_prev_q, ncs_prev_q;
    state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [15:0] sr_q, sr_d;
    logic ovf_q, ovf_d;
    logic commit, wr_pulse_q;
    logic [7:0] regs_q [NUM_REGS];

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (.clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst_n(rst_n), .d(ncs),  .q(ncs_s));

    wire sclk_rise = sclk_s & ~sclk_prev_q;
    wire ncs_fall  = ~ncs_s & ncs_prev_q;
    wire ncs_rise  = ncs_s & ~ncs_prev_q;
    wire [6:0] addr = sr_q[14:8];

    // ncs edges take priority over a coincident sclk edge: a rise commits the
    // bits already shifted, a fall (seen only in IDLE) restarts the frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ovf_d   = ovf_q;
        commit  = 1'b0;
        if (state_q == IDLE) begin
            if (ncs_fall) begin
                state_d = SHIFT;
                cnt_d   = '0;
                sr_d    = '0;
                ovf_d   = 1'b0;
            end
        end else if (ncs_rise) begin
            state_d = IDLE;
            // Registers beyond NUM_REGS do not exist even if MAX_ADDR is raised.
            commit  = cnt_q == CNT_FULL && !ovf_q && sr_q[15]
                      && addr <= 7'(MAX_ADDR) && addr < 7'(NUM_REGS);
        end else if (sclk_rise) begin
            sr_d  = {sr_q[14:0], copi_s};
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 5'd1;
            ovf_d = ovf_q | (cnt_d == CNT_SAT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            ovf_q       <= 1'b0;
            wr_pulse_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            sclk_prev_q <= sclk_s;
            ncs_prev_q  <= ncs_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            ovf_q       <= ovf_d;
            wr_pulse_q  <= commit;
            for (int i = 0; i < NUM_REGS; i++)
                if (commit && addr == 7'(i)) regs_q[i] <= sr_q[7:0];
        end
    end

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_7_0];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_15_8];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_7_0];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_15_8];
    assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];
    assign wr_pulse        = wr_pulse_q;
endmodule
